// File: rtl/mcpu_alu_seq.sv
// ---------------------------------------------------------------------------
// mcpu_alu_seq
//
// Sequential, handshaked ALU for the microCPU. The control unit presents an
// opcode and two operands on a valid/ready request channel. The block returns
// the result on a valid/ready response channel. AND/OR/XOR finish one cycle
// after acceptance. ADD is computed bit-serially, LSB first, through a single
// full-adder slice. It therefore takes WORD_SIZE cycles. Opcode encoding and
// result/OVERFLOW meaning are the same as in the combinational MCPU_Alu, so
// either block can sit behind the same issuer.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   req_valid  initiator presents opcode/r1/r2
//   req_ready  block can accept a request this cycle (state == IDLE)
//   opcode     00 AND, 01 OR, 10 XOR, 11 ADD (upper bits, if any, ignored)
//   r1, r2     operands A and B
//   resp_valid out/OVERFLOW hold a completed result
//   resp_ready consumer takes the result this cycle
//   out        result, truncated to WORD_SIZE bits
//   OVERFLOW   unsigned carry-out of ADD; 0 for logic ops
// ---------------------------------------------------------------------------
module mcpu_alu_seq #(
    parameter int CMD_SIZE  = 2,
    parameter int WORD_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [CMD_SIZE-1:0]  opcode,
    input  logic [WORD_SIZE-1:0] r1,
    input  logic [WORD_SIZE-1:0] r2,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [WORD_SIZE-1:0] out,
    output logic                 OVERFLOW
);

    localparam int CNT_W = (WORD_SIZE > 2) ? $clog2(WORD_SIZE) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_SIZE - 1);

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_ADD = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        EXEC_LOGIC,
        ADD_RUN,
        RESP
    } state_t;

    state_t state;
    state_t state_next;

    logic [1:0]           op_q;
    logic [WORD_SIZE-1:0] a_q;
    logic [WORD_SIZE-1:0] b_q;
    logic [WORD_SIZE-1:0] out_q;
    logic                 ovf_q;
    logic                 carry_q;
    logic [CNT_W-1:0]     cnt_q;

    logic                 accept;
    logic                 last_bit;
    logic                 slice_a;
    logic                 slice_b;
    logic                 slice_sum;
    logic                 slice_carry;
    logic [WORD_SIZE-1:0] logic_result;
    logic [1:0]           op_low;

    // Only the two low opcode bits carry meaning; wider opcodes are folded
    // down to them, so an unknown encoding behaves like its low 2 bits.
    assign op_low = opcode[1:0];

    // Handshake flags come straight from the state register. req_ready must
    // not depend on req_valid, so an initiator can never form a loop with us.
    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign accept     = (state == IDLE) && req_valid;
    assign last_bit   = (cnt_q == LAST_BIT);

    assign out      = out_q;
    assign OVERFLOW = ovf_q;

    // The single full-adder slice used by ADD. The counter picks which bit of
    // the latched operands is being summed this cycle. The running carry
    // links each bit to the next.
    always_comb begin
        slice_a     = a_q[cnt_q];
        slice_b     = b_q[cnt_q];
        slice_sum   = slice_a ^ slice_b ^ carry_q;
        slice_carry = (slice_a & slice_b) | (slice_a & carry_q) | (slice_b & carry_q);
    end

    // One-cycle result for the bitwise operations. ADD never reaches this
    // path, so that encoding just yields zero.
    always_comb begin
        logic_result = '0;
        case (op_q)
            OP_AND:  logic_result = a_q & b_q;
            OP_OR:   logic_result = a_q | b_q;
            OP_XOR:  logic_result = a_q ^ b_q;
            default: logic_result = '0;
        endcase
    end

    // State register. Reset wins over any accept or response handshake
    // that would otherwise happen on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. After an accept, the opcode chooses between the
    // one-cycle logic path and the serial adder. A finished result waits in
    // RESP until the consumer takes it. The return to IDLE happens on the
    // handshake edge itself, so a new request can only be accepted one edge
    // later.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_next = (op_low == OP_ADD) ? ADD_RUN : EXEC_LOGIC;
                end
            end
            EXEC_LOGIC: begin
                state_next = RESP;
            end
            ADD_RUN: begin
                if (last_bit) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath registers. Operands are latched on accept, so the initiator is
    // free to change its inputs afterwards. During ADD each edge writes one
    // result bit and advances the carry. The carry out of the top bit becomes
    // OVERFLOW. Results stay put in RESP and IDLE. A reset drops an
    // in-flight request without a trace.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            out_q   <= '0;
            ovf_q   <= 1'b0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q    <= op_low;
                        a_q     <= r1;
                        b_q     <= r2;
                        carry_q <= 1'b0;
                        cnt_q   <= '0;
                    end
                end
                EXEC_LOGIC: begin
                    out_q <= logic_result;
                    ovf_q <= 1'b0;
                end
                ADD_RUN: begin
                    out_q[cnt_q] <= slice_sum;
                    carry_q      <= slice_carry;
                    if (last_bit) begin
                        ovf_q <= slice_carry;
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mcpu_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_mcpu_alu_seq
//
// Self-checking bench for mcpu_alu_seq at its default size (8-bit words).
// A latency/queue-based reference model follows every clock edge. A
// per-cycle compare process checks the handshake flags and the held result
// against that model. It also checks each response against an in-order
// scoreboard. Directed cases pin the model with hand-computed values.
// ---------------------------------------------------------------------------
module tb_mcpu_alu_seq;

    logic       clk;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] opcode;
    logic [7:0] r1;
    logic [7:0] r2;
    logic       resp_valid;
    logic       resp_ready;
    logic [7:0] out;
    logic       OVERFLOW;

    int checks   = 0;
    int failures = 0;

    mcpu_alu_seq #(.CMD_SIZE(2), .WORD_SIZE(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .opcode     (opcode),
        .r1         (r1),
        .r2         (r2),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .out        (out),
        .OVERFLOW   (OVERFLOW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state. Results are plain arithmetic on the operands.
    // Timing is "result appears N edges after accept, leaves on handshake".
    bit         model_live = 1'b0;
    bit         model_busy = 1'b0;
    bit         model_rv   = 1'b0;
    int         model_wait = 0;
    logic [7:0] exp_out    = '0;
    logic       exp_ovf    = 1'b0;
    logic [7:0] pend_out   = '0;
    logic       pend_ovf   = 1'b0;
    logic [8:0] sbq[$];
    int         responses  = 0;

    // Reference result of one request: {carry, result}.
    function automatic logic [8:0] refResult(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] r;
        case (op)
            2'b00:   r = {1'b0, a & b};
            2'b01:   r = {1'b0, a | b};
            2'b10:   r = {1'b0, a ^ b};
            default: r = {1'b0, a} + {1'b0, b};
        endcase
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // The model samples inputs at the same edge as the DUT. Inputs are only
    // ever changed at the falling edge, so there is no race here.
    always @(posedge clk) begin
        logic [8:0] res;
        if (reset) begin
            model_live = 1'b1;
            model_busy = 1'b0;
            model_rv   = 1'b0;
            model_wait = 0;
            exp_out    = '0;
            exp_ovf    = 1'b0;
            sbq.delete();
        end else if (model_live) begin
            if (!model_busy) begin
                if (req_valid) begin
                    res        = refResult(opcode, r1, r2);
                    pend_out   = res[7:0];
                    pend_ovf   = res[8];
                    sbq.push_back(res);
                    model_busy = 1'b1;
                    model_wait = (opcode == 2'b11) ? 8 : 1;
                end
            end else if (!model_rv) begin
                model_wait--;
                if (model_wait == 0) begin
                    model_rv = 1'b1;
                    exp_out  = pend_out;
                    exp_ovf  = pend_ovf;
                end
            end else if (resp_ready) begin
                model_rv   = 1'b0;
                model_busy = 1'b0;
            end
        end
    end

    // Per-cycle compare, just after each falling edge. The result is checked
    // while it is defined: during a response, and while idle, where the last
    // result (or the reset value) must be held. A handshake about to happen
    // pops the scoreboard, which catches lost or duplicated responses.
    always @(negedge clk) begin
        logic [8:0] front;
        #1;
        if (model_live) begin
            checkOutput("req_ready", req_ready, !model_busy);
            checkOutput("resp_valid", resp_valid, model_rv);
            if (model_rv || !model_busy) begin
                checkOutput("out", out, exp_out);
                checkOutput("overflow", OVERFLOW, exp_ovf);
            end
            if (resp_valid && resp_ready && !reset) begin
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL sb_pop: got response %0d with no request outstanding", out);
                end else begin
                    front = sbq.pop_front();
                    responses++;
                    checkOutput("sb_result", {OVERFLOW, out}, front);
                end
            end
        end
    end

    // Issue one request, wait for its response, optionally hold off the
    // consumer for 'stall' cycles, then take it. Returns what the DUT showed
    // and how many cycles after the accept edge resp_valid appeared. With
    // 'churn' set, the request inputs are scrambled every cycle after accept.
    task automatic applyStimulus(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                                 input int stall, input bit churn,
                                 output logic [7:0] got_out, output logic got_ovf, output int lat);
        int guard;
        guard = 0;
        resp_ready = 1'b0;
        @(negedge clk);
        while (!req_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("accept_timeout", guard < 100, 1);
        req_valid = 1'b1;
        opcode    = op;
        r1        = a;
        r2        = b;
        @(negedge clk);
        req_valid = churn;
        lat = 0;
        while (!resp_valid && lat < 100) begin
            if (churn) begin
                opcode = 2'($urandom_range(0, 3));
                r1     = 8'($urandom_range(0, 255));
                r2     = 8'($urandom_range(0, 255));
            end
            @(negedge clk);
            lat++;
        end
        checkOutput("resp_timeout", lat < 100, 1);
        got_out = out;
        got_ovf = OVERFLOW;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            checkOutput("stall_valid", resp_valid, 1);
            checkOutput("stall_ready", req_ready, 0);
            checkOutput("stall_out", out, got_out);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        req_valid  = 1'b0;
    endtask

    initial begin
        logic [7:0] o;
        logic       v;
        int         lat;
        int         issued;
        int         guard;
        int         resp_before;
        bit         will_accept;

        reset      = 1'b1;
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        opcode     = '0;
        r1         = '0;
        r2         = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("rst_req_ready", req_ready, 1);
        checkOutput("rst_resp_valid", resp_valid, 0);
        checkOutput("rst_out", out, 0);
        checkOutput("rst_ovf", OVERFLOW, 0);

        $display("[TB] directed logic and add cases");
        applyStimulus(2'b00, 8'd4, 8'd5, 0, 1'b0, o, v, lat);
        checkOutput("and_out", o, 4);
        checkOutput("and_ovf", v, 0);
        checkOutput("and_lat", lat, 1);
        applyStimulus(2'b01, 8'd3, 8'd5, 0, 1'b0, o, v, lat);
        checkOutput("or_out", o, 7);
        checkOutput("or_lat", lat, 1);
        applyStimulus(2'b10, 8'd3, 8'd5, 0, 1'b0, o, v, lat);
        checkOutput("xor_out", o, 6);
        checkOutput("xor_ovf", v, 0);
        applyStimulus(2'b11, 8'd4, 8'd5, 0, 1'b0, o, v, lat);
        checkOutput("add_out", o, 9);
        checkOutput("add_ovf", v, 0);
        checkOutput("add_lat", lat, 8);
        applyStimulus(2'b11, 8'd200, 8'd100, 0, 1'b0, o, v, lat);
        checkOutput("addc_out", o, 44);
        checkOutput("addc_ovf", v, 1);
        checkOutput("addc_lat", lat, 8);
        applyStimulus(2'b11, 8'd255, 8'd1, 0, 1'b0, o, v, lat);
        checkOutput("adde_out", o, 0);
        checkOutput("adde_ovf", v, 1);

        $display("[TB] backpressure");
        applyStimulus(2'b11, 8'd3, 8'd5, 5, 1'b0, o, v, lat);
        checkOutput("bp_out", o, 8);
        checkOutput("bp_ovf", v, 0);
        #1;
        checkOutput("bp_after_ready", req_ready, 1);
        checkOutput("bp_after_valid", resp_valid, 0);
        checkOutput("bp_after_out", out, 8);

        $display("[TB] input churn during add");
        applyStimulus(2'b11, 8'd100, 8'd27, 0, 1'b1, o, v, lat);
        checkOutput("churn_out", o, 127);
        checkOutput("churn_ovf", v, 0);

        $display("[TB] reset in the middle of an add");
        @(negedge clk);
        req_valid = 1'b1;
        opcode    = 2'b11;
        r1        = 8'd200;
        r2        = 8'd100;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("midrst_out", out, 0);
        checkOutput("midrst_ovf", OVERFLOW, 0);
        checkOutput("midrst_valid", resp_valid, 0);
        checkOutput("midrst_ready", req_ready, 1);
        reset = 1'b0;
        applyStimulus(2'b00, 8'd4, 8'd0, 0, 1'b0, o, v, lat);
        checkOutput("postrst_out", o, 0);
        checkOutput("postrst_lat", lat, 1);

        $display("[TB] random stream of 50 requests");
        resp_before = responses;
        issued      = 0;
        guard       = 0;
        will_accept = 1'b0;
        req_valid   = 1'b0;
        while (issued < 50 && guard < 5000) begin
            @(negedge clk);
            guard++;
            if (will_accept) begin
                issued++;
                req_valid = 1'b0;
            end
            if (!req_valid && issued < 50 && $urandom_range(0, 3) != 0) begin
                req_valid = 1'b1;
                opcode    = 2'($urandom_range(0, 3));
                r1        = 8'($urandom_range(0, 255));
                r2        = 8'($urandom_range(0, 255));
            end
            resp_ready  = 1'($urandom_range(0, 1));
            will_accept = req_valid && req_ready;
        end
        req_valid = 1'b0;
        checkOutput("stream_issue", issued, 50);
        guard = 0;
        while ((model_busy || sbq.size() != 0) && guard < 500) begin
            @(negedge clk);
            guard++;
            resp_ready = 1'($urandom_range(0, 1));
        end
        resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("stream_drain", sbq.size(), 0);
        checkOutput("stream_count", responses - resp_before, 50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
